multu_hilo_unit: RTL and testbench

Sequential unsigned multiplier with architectural HI/LO registers for the MIPS single-cycle CPU. The execute stage issues MULTU into it, and MFHI/MFLO later read its results. A multiplication takes a fixed WIDTH cycles of shift-add iteration. While it runs, the unit raises a stall toward the CPU so that dependent MFHI/MFLO instructions, or a second MULTU, do not read or issue too early. It is an execute-side neighbour of the CPU datapath: the datapath feeds it operands and consumes HI/LO.

---
 rtl/multu_hilo_unit.sv | 96 +++++++++
 tb/tb_multu_hilo_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit
// Sequential unsigned shift-add multiplier that owns the architectural HI/LO
// registers. MULTU issues through start. The result appears in HI/LO after
// WIDTH iterations. MFHI/MFLO read hi/lo directly. stall freezes the CPU
// while a multiply is in flight and the current instruction depends on it.
//
// Ports
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   start   MULTU issue strobe (ignored while busy)
//   src_a   multiplicand, sampled when start is accepted
//   src_b   multiplier, sampled when start is accepted
//   mf_req  MFHI/MFLO present this cycle
//   busy    multiplication in progress (registered)
//   done    one-cycle pulse after HI/LO were written (registered)
//   stall   busy & (start | mf_req), combinational
//   hi, lo  upper / lower half of the last completed product
//
// state | meaning
// IDLE  | waiting for start; HI/LO readable
// RUN   | shift-add iterations in progress, cnt = iteration index
module multu_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mf_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic               state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_iter;

    // The accumulation cannot overflow: the product always fits in 2*WIDTH bits.
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    assign busy  = (state == RUN);
    assign stall = busy & (start | mf_req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, src_a};
                        mplier <= src_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        hi    <= acc_next[2*WIDTH-1:WIDTH];
                        lo    <= acc_next[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multu_hilo_unit.sv
module tb_multu_hilo_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mf_req;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int vectors = 0;
    int miscompares = 0;

    logic [2*WIDTH-1:0] exp_q[$];

    multu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .src_a (src_a),
        .src_b (src_b),
        .mf_req(mf_req),
        .busy  (busy),
        .done  (done),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [2*WIDTH-1:0] e;
                e = exp_q.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
                check("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int n;
        @(negedge clk);
        start = 1'b1; src_a = a; src_b = b;
        exp_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'd32);
        check("done_pulse", {63'd0, done}, 64'd1);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b1; src_a = 32'd7; src_b = 32'd3; mf_req = 1'b0;

        // Reset with start asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst_no_start", {63'd0, busy}, 64'd0);

        // Basic, max, mixed
        run_op(32'd3, 32'd5, 32'd0, 32'h0000000F);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op(32'h80000000, 32'd2, 32'd1, 32'd0);

        // Stall and ignored second start
        @(negedge clk);
        start = 1'b1; src_a = 32'h10000; src_b = 32'h10000;
        exp_q.push_back({32'd1, 32'd0});
        @(negedge clk);
        start = 1'b0; mf_req = 1'b1;
        n = 0;
        for (int j = 0; j < 100; j++) begin
            start = (j == 4);
            if (j == 4) begin src_a = 32'd3; src_b = 32'd3; end
            #1;
            if (stall === 1'b1) n++;
            if (busy !== 1'b1) break;
            @(negedge clk);
        end
        check("stall_cycles", 64'(n), 64'd32);
        check("stall_done_cycle", {63'd0, stall}, 64'd0);
        check("stall_done_pulse", {63'd0, done}, 64'd1);
        check("mf_hi_comb", {32'd0, hi}, 64'd1);
        check("mf_lo_comb", {32'd0, lo}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        mf_req = 1'b0;
        check("ignored_start_idle", {63'd0, busy}, 64'd0);

        // Reset mid-operation
        start = 1'b1; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        repeat (40) @(negedge clk);
        check("abort_stays_idle", {63'd0, busy}, 64'd0);
        run_op(32'd2, 32'd4, 32'd0, 32'd8);

        // Back-to-back
        @(negedge clk);
        start = 1'b1; src_a = 32'd6; src_b = 32'd7;
        exp_q.push_back({32'd0, 32'd42});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("b2b_first_latency", 64'(n), 64'd32);
        start = 1'b1; src_a = 32'h0000FFFF; src_b = 32'h00010001;
        exp_q.push_back({32'd0, 32'hFFFFFFFF});
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("b2b_busy_cycles", 64'(n), 64'd32);
        check("b2b_done", {63'd0, done}, 64'd1);
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
